// File: rtl/utf8_pkg.sv
// Shared types, constants and lead/second-byte lookups for the streaming UTF-8 decoder.
package utf8_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NEED1 = 2'd1,
        NEED2 = 2'd2,
        NEED3 = 2'd3
    } state_t;

    localparam logic [20:0] REPLACEMENT_CP = 21'h00FFFD;
    localparam logic [20:0] BOM_CP         = 21'h00FEFF;

    // Total sequence length for a lead byte; 0 marks a byte that can never start a sequence.
    function automatic logic [2:0] lead_len(input logic [7:0] b);
        if (b <= 8'h7F)                     return 3'd1;
        else if (b >= 8'hC2 && b <= 8'hDF)  return 3'd2;
        else if (b >= 8'hE0 && b <= 8'hEF)  return 3'd3;
        else if (b >= 8'hF0 && b <= 8'hF4)  return 3'd4;
        else                                return 3'd0;
    endfunction

    // The first continuation byte is narrowed to reject overlongs, surrogates and > U+10FFFF.
    function automatic logic [7:0] second_min(input logic [7:0] lead);
        case (lead)
            8'hE0:   return 8'hA0;
            8'hF0:   return 8'h90;
            default: return 8'h80;
        endcase
    endfunction

    function automatic logic [7:0] second_max(input logic [7:0] lead);
        case (lead)
            8'hED:   return 8'h9F;
            8'hF4:   return 8'h8F;
            default: return 8'hBF;
        endcase
    endfunction

endpackage

// File: rtl/utf8_lead_classify.sv
// Combinational lead-byte classifier: next decoder state, initial payload bits, illegal flag.
module utf8_lead_classify
    import utf8_pkg::*;
(
    input  logic [7:0] lead_byte,
    output state_t     next_state,
    output logic [6:0] payload,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        next_state = IDLE;
        payload    = 7'd0;
        illegal    = 1'b0;
        case (lead_len(lead_byte))
            3'd1: payload = lead_byte[6:0];
            3'd2: begin
                next_state = NEED1;
                payload    = {2'd0, lead_byte[4:0]};
            end
            3'd3: begin
                next_state = NEED2;
                payload    = {3'd0, lead_byte[3:0]};
            end
            3'd4: begin
                next_state = NEED3;
                payload    = {4'd0, lead_byte[2:0]};
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/utf8_decoder.sv
// Streaming UTF-8 decoder: one byte in per handshake, one code point (or U+FFFD) out per handshake.
module utf8_decoder
    import utf8_pkg::*;
#(
    parameter bit STRIP_BOM = 1'b1,
    parameter int ERR_W     = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic             out_valid,
    output logic [20:0]      out_cp,
    output logic             out_err,
    input  logic             out_ready,
    output logic [ERR_W-1:0] err_count
);

    state_t      state;
    logic [14:0] acc;
    logic [7:0]  lead;
    logic        second;
    logic        first;

    state_t      cls_next;
    logic [6:0]  cls_payload;
    logic        cls_illegal;

    logic        space;
    logic        cont_ok;
    logic        bad_cont;
    logic        take;
    logic        emit;
    logic        emit_err;
    logic        suppress;
    logic [20:0] emit_cp;
    logic [20:0] acc_next;

    utf8_lead_classify u_classify (
        .lead_byte  (in_byte),
        .next_state (cls_next),
        .payload    (cls_payload),
        .illegal    (cls_illegal)
    );

    assign space    = !out_valid || out_ready;
    assign acc_next = {acc, in_byte[5:0]};
    assign cont_ok  = second ? (in_byte >= second_min(lead) && in_byte <= second_max(lead))
                             : (in_byte[7:6] == 2'b10);
    // A bad continuation is never consumed: it is replayed as a lead once the error is out.
    assign bad_cont = in_valid && (state != IDLE) && !cont_ok;
    assign in_ready = space && !bad_cont;
    assign take     = in_valid && in_ready;

    always_comb begin
        emit     = 1'b0;
        emit_cp  = REPLACEMENT_CP;
        emit_err = 1'b0;
        if (state == IDLE) begin
            if (take) begin
                if (cls_illegal) begin
                    emit     = 1'b1;
                    emit_err = 1'b1;
                end else if (cls_next == IDLE) begin
                    emit    = 1'b1;
                    emit_cp = {14'd0, cls_payload};
                end
            end
        end else if (bad_cont) begin
            if (space) begin
                emit     = 1'b1;
                emit_err = 1'b1;
            end
        end else if (take && state == NEED1) begin
            emit    = 1'b1;
            emit_cp = acc_next;
        end
    end

    assign suppress = STRIP_BOM && first && !emit_err && (emit_cp == BOM_CP);

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            lead      <= '0;
            second    <= 1'b0;
            first     <= 1'b1;
            out_valid <= 1'b0;
            out_cp    <= '0;
            out_err   <= 1'b0;
            err_count <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;

            if (emit) begin
                first <= 1'b0;
                if (!suppress) begin
                    out_valid <= 1'b1;
                    out_cp    <= emit_cp;
                    out_err   <= emit_err;
                    if (emit_err && err_count != {ERR_W{1'b1}})
                        err_count <= err_count + ERR_W'(1);
                end
            end

            if (state == IDLE) begin
                if (take && !cls_illegal && cls_next != IDLE) begin
                    state  <= cls_next;
                    acc    <= {8'd0, cls_payload};
                    lead   <= in_byte;
                    second <= 1'b1;
                end
            end else if (bad_cont) begin
                if (space) begin
                    state  <= IDLE;
                    second <= 1'b0;
                end
            end else if (take) begin
                acc    <= acc_next[14:0];
                second <= 1'b0;
                case (state)
                    NEED3:   state <= NEED2;
                    NEED2:   state <= NEED1;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_utf8_decoder.sv
// Bench for utf8_decoder: two instances (BOM strip / 16-bit errors, no strip / 2-bit errors) vs a byte-walk model.
module tb_utf8_decoder;

    logic        clock = 1'b0;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_err, a_out_ready;
    logic [7:0]  a_in_byte;
    logic [20:0] a_out_cp;
    logic [15:0] a_err_count;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_err, b_out_ready;
    logic [7:0]  b_in_byte;
    logic [20:0] b_out_cp;
    logic [1:0]  b_err_count;

    logic [7:0]  stream[$];
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [21:0] ea[$];
    logic [21:0] eb[$];
    logic [21:0] mq[$];
    int          merr;
    int          exp_err_a, exp_err_b;
    int          checks = 0;
    int          passed = 0;
    int          a_acc_cyc, a_first_out;

    always #5 clock = ~clock;

    utf8_decoder #(.STRIP_BOM(1'b1), .ERR_W(16)) dut_a (
        .clock(clock), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_byte(a_in_byte), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_cp(a_out_cp), .out_err(a_out_err),
        .out_ready(a_out_ready), .err_count(a_err_count)
    );

    utf8_decoder #(.STRIP_BOM(1'b0), .ERR_W(2)) dut_b (
        .clock(clock), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_byte(b_in_byte), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_cp(b_out_cp), .out_err(b_out_err),
        .out_ready(b_out_ready), .err_count(b_err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: walk the byte array with the UTF-8 well-formedness rules, producing {err, cp} items.
    task automatic model_decode(input bit strip, input int sat);
        int   i, n, need, k, cp;
        bit   first, bad, trunc;
        logic [7:0] b, c, lo, hi;
        mq.delete();
        merr  = 0;
        first = 1'b1;
        i     = 0;
        n     = stream.size();
        while (i < n) begin
            b = stream[i];
            if (b < 8'h80)                     begin need = 0;  cp = int'(b); end
            else if (b >= 8'hC2 && b <= 8'hDF) begin need = 1;  cp = int'(b) - 'hC0; end
            else if (b >= 8'hE0 && b <= 8'hEF) begin need = 2;  cp = int'(b) - 'hE0; end
            else if (b >= 8'hF0 && b <= 8'hF4) begin need = 3;  cp = int'(b) - 'hF0; end
            else                               begin need = -1; cp = 'hFFFD; end
            bad   = (need < 0);
            trunc = 1'b0;
            k     = 1;
            while (!bad && !trunc && k <= need) begin
                if (i + k >= n) trunc = 1'b1;
                else begin
                    c  = stream[i+k];
                    lo = 8'h80;
                    hi = 8'hBF;
                    if (k == 1) begin
                        if (b == 8'hE0) lo = 8'hA0;
                        if (b == 8'hED) hi = 8'h9F;
                        if (b == 8'hF0) lo = 8'h90;
                        if (b == 8'hF4) hi = 8'h8F;
                    end
                    if (c < lo || c > hi) bad = 1'b1;
                    else begin
                        cp = cp * 64 + (int'(c) - 'h80);
                        k++;
                    end
                end
            end
            if (trunc) break;
            if (bad) begin
                cp = 'hFFFD;
                i  = i + k;
            end else begin
                i = i + need + 1;
            end
            if (first && strip && !bad && cp == 'hFEFF) begin
                // leading BOM dropped
            end else begin
                mq.push_back({bad, 21'(cp)});
                if (bad && merr < sat) merr++;
            end
            first = 1'b0;
        end
    endtask

    task automatic push_cp(input int cp);
        if (cp < 'h80) stream.push_back(8'(cp));
        else if (cp < 'h800) begin
            stream.push_back(8'('hC0 + cp / 64));
            stream.push_back(8'('h80 + cp % 64));
        end else if (cp < 'h10000) begin
            stream.push_back(8'('hE0 + cp / 4096));
            stream.push_back(8'('h80 + (cp / 64) % 64));
            stream.push_back(8'('h80 + cp % 64));
        end else begin
            stream.push_back(8'('hF0 + cp / 262144));
            stream.push_back(8'('h80 + (cp / 4096) % 64));
            stream.push_back(8'('h80 + (cp / 64) % 64));
            stream.push_back(8'('h80 + cp % 64));
        end
    endtask

    task automatic gen_random(input int items);
        stream.delete();
        repeat (items) begin
            case ($urandom_range(9))
                0, 1: stream.push_back(8'($urandom));
                2:    push_cp(int'($urandom_range('h7F)));
                3:    push_cp(int'($urandom_range('h7FF, 'h80)));
                4, 5: push_cp(int'($urandom_range('hFFFF, 'h800)));
                6:    push_cp(int'($urandom_range('h10FFFF, 'h10000)));
                7:    push_cp('hFEFF);
                8:    stream.push_back(8'($urandom_range('hBF, 'h80)));
                default: stream.push_back(8'($urandom_range('hF4, 'hC2)));
            endcase
        end
    endtask

    task automatic check_side(input string side, input logic ov, input logic oready, input logic ir,
                              input logic [20:0] cp, input logic oe, input bit have_exp,
                              input logic [21:0] exp_item, inout bit stalled, inout logic [21:0] held);
        if (stalled) check({side, " hold"}, {9'd0, ov, oe, cp}, {9'd0, 1'b1, held});
        if (ov && !oready) check({side, " in_ready_while_full"}, {31'd0, ir}, 32'd0);
        if (ov && oready) begin
            if (!have_exp) check({side, " extra_output"}, {31'd0, ov}, 32'd0);
            else check({side, " item"}, {10'd0, oe, cp}, {10'd0, exp_item});
        end
        stalled = ov && !oready;
        held    = {oe, cp};
    endtask

    // rmode: 0 out_ready=1, 1 random, 2 stall 3 cycles on the first valid output then 1.
    task automatic run_segment(input int rmode, input bit gaps);
        bit          a_st = 0, b_st = 0, done = 0;
        logic [21:0] a_held = '0, b_held = '0;
        int          a_left = 3, b_left = 3;
        int          budget = 30 * stream.size() + 60;

        @(posedge clock); #1;
        rst_n = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        @(posedge clock); #1;
        rst_n = 1'b1;
        #1;
        check("a reset outputs", {10'd0, a_out_valid, a_out_err, a_out_cp}, 32'd0);
        check("a reset err_count", {16'd0, a_err_count}, 32'd0);
        check("a reset in_ready", {31'd0, a_in_ready}, 32'd1);
        check("b reset outputs", {10'd0, b_out_valid, b_out_err, b_out_cp}, 32'd0);
        check("b reset err_count", {30'd0, b_err_count}, 32'd0);

        model_decode(1'b1, 65535); ea = mq; exp_err_a = merr;
        model_decode(1'b0, 3);     eb = mq; exp_err_b = merr;
        qa = stream;
        qb = stream;
        a_acc_cyc   = -1;
        a_first_out = -1;

        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(posedge clock); #1;
            a_in_valid = (qa.size() > 0) && (!gaps || $urandom_range(3) != 0);
            a_in_byte  = (qa.size() > 0) ? qa[0] : 8'($urandom);
            b_in_valid = (qb.size() > 0) && (!gaps || $urandom_range(3) != 0);
            b_in_byte  = (qb.size() > 0) ? qb[0] : 8'($urandom);
            if (rmode == 1) begin
                a_out_ready = 1'($urandom_range(1));
                b_out_ready = 1'($urandom_range(1));
            end else if (rmode == 2) begin
                a_out_ready = 1'b1;
                b_out_ready = 1'b1;
                if (a_out_valid && a_left > 0) begin a_out_ready = 1'b0; a_left--; end
                if (b_out_valid && b_left > 0) begin b_out_ready = 1'b0; b_left--; end
            end else begin
                a_out_ready = 1'b1;
                b_out_ready = 1'b1;
            end
            #1;
            if (a_out_valid && a_first_out < 0) a_first_out = cyc;
            check_side("a", a_out_valid, a_out_ready, a_in_ready, a_out_cp, a_out_err,
                       ea.size() > 0, (ea.size() > 0) ? ea[0] : 22'd0, a_st, a_held);
            check_side("b", b_out_valid, b_out_ready, b_in_ready, b_out_cp, b_out_err,
                       eb.size() > 0, (eb.size() > 0) ? eb[0] : 22'd0, b_st, b_held);
            if (a_out_valid && a_out_ready && ea.size() > 0) void'(ea.pop_front());
            if (b_out_valid && b_out_ready && eb.size() > 0) void'(eb.pop_front());
            if (a_in_valid && a_in_ready) begin void'(qa.pop_front()); a_acc_cyc = cyc; end
            if (b_in_valid && b_in_ready) void'(qb.pop_front());
            done = (qa.size() == 0) && (qb.size() == 0) && (ea.size() == 0) && (eb.size() == 0);
        end
        check("segment completes within budget", {31'd0, done}, 32'd1);

        repeat (3) begin
            @(posedge clock); #1;
            a_in_valid = 1'b0; b_in_valid = 1'b0;
            a_out_ready = 1'b1; b_out_ready = 1'b1;
            #1;
            check("a no trailing output", {31'd0, a_out_valid}, 32'd0);
            check("b no trailing output", {31'd0, b_out_valid}, 32'd0);
        end
        check("a err_count", {16'd0, a_err_count}, 32'(exp_err_a));
        check("b err_count", {30'd0, b_err_count}, 32'(exp_err_b));
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_byte = 8'd0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_byte = 8'd0; b_out_ready = 1'b1;

        stream = '{8'h41};
        run_segment(0, 1'b0);
        check("ascii latency", 32'(a_first_out - a_acc_cyc), 32'd1);

        stream = '{8'hE2, 8'h82, 8'hAC};
        run_segment(0, 1'b0);

        stream = '{8'hEF, 8'hBB, 8'hBF, 8'h41, 8'hEF, 8'hBB, 8'hBF};
        run_segment(1, 1'b0);

        stream = '{8'hE0, 8'h80};
        run_segment(0, 1'b0);

        stream = '{8'hF0, 8'h9F, 8'h98, 8'h80, 8'h41};
        run_segment(2, 1'b0);

        stream = '{8'hED, 8'hA0, 8'h80, 8'hF4, 8'h90, 8'hC0};
        run_segment(1, 1'b1);

        stream = '{8'hE2, 8'h82};
        run_segment(0, 1'b0);
        stream = '{8'h41};
        run_segment(0, 1'b0);

        stream = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_segment(1, 1'b0);

        for (int s = 0; s < 12; s++) begin
            gen_random(int'($urandom_range(30, 8)));
            run_segment(int'($urandom_range(2)), 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
